serial_cfg_rx: RTL and testbench

Serial configuration receiver at the front of the backend, in the main clock domain. It consumes the configuration stream driven from the FPGA on sclk/sdin and decodes it into gain and reset control registers for the amplifier and VCO stages. It raises o_ready to the FPGA once a commit frame has been accepted. sclk is treated as data: it is oversampled by i_clk, never used as a clock.

---
 rtl/serial_cfg_rx.sv | 178 +++++++++++++++++
 tb/tb_serial_cfg_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_cfg_rx.sv
// Serial configuration receiver: oversamples sclk/sdin in the i_clk domain and
// decodes 12-bit frames into amplifier/VCO gain and reset control registers.
module serial_cfg_rx #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned SCLK_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_resetbAll,
    input  logic       i_sclk,
    input  logic       i_sdin,
    output logic [2:0] o_gainA1,
    output logic [1:0] o_gainA2,
    output logic       o_resetb1,
    output logic       o_resetb2,
    output logic       o_resetbvco1,
    output logic       o_resetbvco2,
    output logic       o_ready,
    output logic       o_frame_err
);

    localparam int unsigned FRAME_W = 12;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TO_W    = $clog2(SCLK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [2:0]             gain_a1_q, gain_a1_d;
    logic [1:0]             gain_a2_q, gain_a2_d;
    logic [3:0]             rstb_q, rstb_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    logic               sclk_s;
    logic               sdin_s;
    logic               sclk_rise;
    logic               frame_ok;
    logic [FRAME_W-1:0] shift_in;

    // Synchronizers and sclk rising-edge detect
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
        sdin_sync_d = {sdin_sync_q[SYNC_STAGES-2:0], i_sdin};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        sdin_s      = sdin_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        shift_in    = {shift_q[FRAME_W-2:0], sdin_s};
        frame_ok    = (shift_q[11:8] == 4'hA) && !(^shift_q);
    end

    // Frame FSM, timeout and register decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        gain_a1_d = gain_a1_q;
        gain_a2_d = gain_a2_q;
        rstb_d    = rstb_q;
        ready_d   = ready_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    shift_d  = shift_in;
                    to_cnt_d = '0;
                    if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(SCLK_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_CHECK: begin
                to_cnt_d = '0;
                if (!frame_ok) begin
                    err_d = 1'b1;
                end else begin
                    case (shift_q[7:6])
                        2'b00: begin
                            gain_a1_d = shift_q[5:3];
                            gain_a2_d = shift_q[2:1];
                            ready_d   = 1'b0;
                        end
                        2'b01: begin
                            rstb_d  = shift_q[4:1];
                            ready_d = 1'b0;
                        end
                        2'b10:   ready_d = 1'b1;
                        default: err_d   = 1'b1;
                    endcase
                end
                // An edge arriving during CHECK is the first bit of the next frame
                if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = ST_SHIFT;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            sclk_sync_q <= '0;
            sdin_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            gain_a1_q   <= '0;
            gain_a2_q   <= '0;
            rstb_q      <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdin_sync_q <= sdin_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            gain_a1_q   <= gain_a1_d;
            gain_a2_q   <= gain_a2_d;
            rstb_q      <= rstb_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign o_gainA1     = gain_a1_q;
    assign o_gainA2     = gain_a2_q;
    assign o_resetb1    = rstb_q[0];
    assign o_resetb2    = rstb_q[1];
    assign o_resetbvco1 = rstb_q[2];
    assign o_resetbvco2 = rstb_q[3];
    assign o_ready      = ready_q;
    assign o_frame_err  = err_q;

endmodule

// File: tb/tb_serial_cfg_rx.sv
// Bench for serial_cfg_rx: directed frame table, timeout/reset sequences and
// randomized frames checked against a frame-level register model.
module tb_serial_cfg_rx;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       sdin;
    logic [2:0] gain_a1;
    logic [1:0] gain_a2;
    logic       rb1, rb2, rbv1, rbv2;
    logic       ready;
    logic       ferr;

    typedef struct packed {
        logic [2:0] ga1;
        logic [1:0] ga2;
        logic       rb1;
        logic       rb2;
        logic       rbv1;
        logic       rbv2;
        logic       ready;
        logic       err;
    } outs_t;

    typedef struct {
        logic [11:0] frame;
        outs_t       exp;
        string       name;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_cfg_rx #(.SYNC_STAGES(2), .SCLK_TIMEOUT(64)) dut (
        .i_clk        (clk),
        .i_resetbAll  (rst_n),
        .i_sclk       (sclk),
        .i_sdin       (sdin),
        .o_gainA1     (gain_a1),
        .o_gainA2     (gain_a2),
        .o_resetb1    (rb1),
        .o_resetb2    (rb2),
        .o_resetbvco1 (rbv1),
        .o_resetbvco2 (rbv2),
        .o_ready      (ready),
        .o_frame_err  (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t dut_outs();
        outs_t o;
        o.ga1 = gain_a1; o.ga2 = gain_a2;
        o.rb1 = rb1; o.rb2 = rb2; o.rbv1 = rbv1; o.rbv2 = rbv2;
        o.ready = ready; o.err = ferr;
        return o;
    endfunction

    // Register state after one complete frame, straight from the frame rules
    function automatic outs_t model(input outs_t s, input logic [11:0] f);
        outs_t n = s;
        logic [4:0] data = f[5:1];
        if (f[11:8] != 4'hA || (^f) != 1'b0) begin
            n.err = 1'b1;
        end else if (f[7:6] == 2'd0) begin
            n.ga1 = data[4:2]; n.ga2 = data[1:0]; n.ready = 1'b0;
        end else if (f[7:6] == 2'd1) begin
            n.rb1 = data[0]; n.rb2 = data[1]; n.rbv1 = data[2]; n.rbv2 = data[3];
            n.ready = 1'b0;
        end else if (f[7:6] == 2'd2) begin
            n.ready = 1'b1;
        end else begin
            n.err = 1'b1;
        end
        return n;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act = dut_outs();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    // sclk at i_clk/8; each bit ends with sclk high for 4 cycles
    task automatic send_bits(input logic [11:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            sdin = f[11-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sclk = 1'b0; sdin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    vec_t  vecs[8];
    outs_t st;
    outs_t z;

    initial begin
        rst_n = 1'b0; sclk = 1'b0; sdin = 1'b0;
        z = '0;

        // {frame, expected outputs {ga1,ga2,rb1,rb2,rbv1,rbv2,ready,err}}
        vecs[0] = '{12'hA2D, '{3'b101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, "gain_write"};
        vecs[1] = '{12'hA5F, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, "resetb_write"};
        vecs[2] = '{12'hA81, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, "commit"};
        vecs[3] = '{12'hA2D, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, "gain_drops_ready"};
        vecs[4] = '{12'hA2C, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}, "bad_parity"};
        vecs[5] = '{12'h52D, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}, "bad_header"};
        vecs[6] = '{12'hAC0, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}, "reserved_addr"};
        vecs[7] = '{12'hA81, '{3'b101, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}, "err_sticky"};

        do_reset();
        check("reset_state", z);

        // Directed frames, back-to-back
        for (int i = 0; i < 8; i++) begin
            send_bits(vecs[i].frame, 12);
            check(vecs[i].name, vecs[i].exp);
        end

        // Partial frame aborted by sclk timeout, then a clean frame
        do_reset();
        send_bits(12'hA2D, 7);
        sclk = 1'b0;
        repeat (70) @(negedge clk);
        check("timeout_abort", '{3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        send_bits(12'hA2D, 12);
        check("after_timeout", '{3'b101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

        // Asynchronous reset mid-frame
        do_reset();
        send_bits(12'hA5F, 12);
        check("pre_reset_resetb", '{3'b000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        send_bits(12'hA2D, 5);
        #2 rst_n = 1'b0;
        #1 check("async_reset", z);
        @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(12'hA81, 12);
        check("commit_after_reset", '{3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // Randomized frames against the model
        do_reset();
        st = '0;
        for (int i = 0; i < 60; i++) begin
            logic [11:0] f;
            f = 12'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                f[11:8] = 4'hA;
                f[0]    = ^f[11:1];
            end
            send_bits(f, 12);
            st = model(st, f);
            check($sformatf("rand_%0d_%03h", i, f), st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
